// File: rtl/nios2_mul_pkg.sv
// nios2_mul_pkg: shared opcode/state types for the multiply sequencer
package nios2_mul_pkg;
  localparam int CELL_HALF = 16;
  typedef enum logic [1:0] {OP_MUL, OP_MULXUU, OP_MULXSS, OP_MULXSU} op_e;
  typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE} state_e;
endpackage

// File: rtl/nios2_mul_combine.sv
// nios2_mul_combine: assembles partial products into the low or high product word
module nios2_mul_combine
  import nios2_mul_pkg::*;
(
  input  logic [31:0] p1,
  input  logic [31:0] p2,
  input  logic [31:0] p3,
  input  logic [31:0] p_hh,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  op_e         op,
  output logic [31:0] result
);
  logic [32:0] mid, lo_sum;
  logic [31:0] hi_uu, corr_a, corr_b;
  assign mid = {1'b0, p2} + {1'b0, p3};
  assign lo_sum = {1'b0, p1} + {1'b0, mid[CELL_HALF-1:0], 16'h0};
  assign hi_uu = p_hh + {15'h0, mid[32:CELL_HALF]} + {31'h0, lo_sum[32]};
  // signed high word = unsigned high word minus the other operand for each negative signed operand
  assign corr_a = a[31] ? b : '0;
  assign corr_b = (op == OP_MULXSS && b[31]) ? a : '0;
  assign result = op == OP_MUL    ? lo_sum[31:0] :
                  op == OP_MULXUU ? hi_uu : hi_uu - corr_a - corr_b;
endmodule

// File: rtl/nios2_mul_sequencer.sv
// nios2_mul_sequencer: drives the 3-partial-product cell for MUL / MULX* and registers the result
module nios2_mul_sequencer
  import nios2_mul_pkg::*;
#(
  parameter int CELL_LATENCY = 1,
  parameter bit HI_OPS_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
);
  localparam logic [1:0] CNT_LOAD = 2'(CELL_LATENCY - 1);
  state_e state;
  op_e op, comb_op;
  logic [31:0] a, b, p1_r, p2_r, p3_r, result;
  logic [1:0] cnt;
  logic single;
  assign single = op == OP_MUL || !HI_OPS_EN;
  // first pass combines straight from the cell; second pass uses the captured low partials
  assign comb_op = state == WAIT1 ? OP_MUL : op;
  nios2_mul_combine u_combine (
    .p1(state == WAIT1 ? cell_p1 : p1_r),
    .p2(state == WAIT1 ? cell_p2 : p2_r),
    .p3(state == WAIT1 ? cell_p3 : p3_r),
    .p_hh(cell_p1),
    .a(a),
    .b(b),
    .op(comb_op),
    .result(result)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      cell_en <= 1'b0;
      out_result <= '0;
      cell_src1 <= '0;
      cell_src2 <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op <= op_e'(in_op);
          a <= in_src1;
          b <= in_src2;
          cell_src1 <= in_src1;
          cell_src2 <= in_src2;
          cell_en <= 1'b1;
          in_ready <= 1'b0;
          state <= ISSUE1;
        end
        ISSUE1: begin
          cell_en <= 1'b0;
          cnt <= CNT_LOAD;
          state <= WAIT1;
        end
        WAIT1: if (cnt == 2'd0) begin
          p1_r <= cell_p1;
          p2_r <= cell_p2;
          p3_r <= cell_p3;
          if (single) begin
            out_result <= result;
            out_valid <= 1'b1;
            state <= DONE;
          end else begin
            cell_src1 <= {16'h0, a[31:CELL_HALF]};
            cell_src2 <= {16'h0, b[31:CELL_HALF]};
            cell_en <= 1'b1;
            state <= ISSUE2;
          end
        end else cnt <= cnt - 2'd1;
        ISSUE2: begin
          cell_en <= 1'b0;
          cnt <= CNT_LOAD;
          state <= WAIT2;
        end
        WAIT2: if (cnt == 2'd0) begin
          out_result <= result;
          out_valid <= 1'b1;
          state <= DONE;
        end else cnt <= cnt - 2'd1;
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nios2_mul_sequencer.sv
// tb_nios2_mul_sequencer: scoreboard bench, instance 0 (latency 1, hi ops) and instance 1 (latency 3, no hi ops)
module tb_nios2_mul_sequencer;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  logic clk = 1'b0;
  logic reset;
  logic in_valid[2], in_ready[2], cell_en[2], out_valid[2], out_ready[2];
  logic [1:0] in_op[2];
  logic [31:0] in_src1[2], in_src2[2], cell_src1[2], cell_src2[2];
  logic [31:0] cell_p1[2], cell_p2[2], cell_p3[2], out_result[2];
  typedef struct {
    int id;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int n_pass = 0;
  int n_total = 0;
  always #5 clk = ~clk;
  nios2_mul_sequencer #(.CELL_LATENCY(LAT0), .HI_OPS_EN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_op(in_op[0]),
    .in_src1(in_src1[0]), .in_src2(in_src2[0]), .cell_src1(cell_src1[0]), .cell_src2(cell_src2[0]),
    .cell_en(cell_en[0]), .cell_p1(cell_p1[0]), .cell_p2(cell_p2[0]), .cell_p3(cell_p3[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_result(out_result[0])
  );
  nios2_mul_sequencer #(.CELL_LATENCY(LAT1), .HI_OPS_EN(1'b0)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_op(in_op[1]),
    .in_src1(in_src1[1]), .in_src2(in_src2[1]), .cell_src1(cell_src1[1]), .cell_src2(cell_src2[1]),
    .cell_en(cell_en[1]), .cell_p1(cell_p1[1]), .cell_p2(cell_p2[1]), .cell_p3(cell_p3[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_result(out_result[1])
  );
  // cell model: 16x16 products registered on cell_en, then delayed through an enable-tagged pipe
  logic [31:0] pd[2][4][3];
  logic pe[2][4];
  function automatic logic [31:0] mul16(logic [15:0] x, logic [15:0] y);
    return {16'h0, x} * {16'h0, y};
  endfunction
  always @(posedge clk)
    for (int g = 0; g < 2; g++) begin
      pe[g][0] <= cell_en[g];
      if (cell_en[g]) begin
        pd[g][0][0] <= mul16(cell_src1[g][15:0], cell_src2[g][15:0]);
        pd[g][0][1] <= mul16(cell_src1[g][15:0], cell_src2[g][31:16]);
        pd[g][0][2] <= mul16(cell_src1[g][31:16], cell_src2[g][15:0]);
      end
      for (int k = 1; k < 4; k++) begin
        pe[g][k] <= pe[g][k-1];
        if (pe[g][k-1]) pd[g][k] <= pd[g][k-1];
      end
    end
  assign cell_p1[0] = pd[0][LAT0-1][0];
  assign cell_p2[0] = pd[0][LAT0-1][1];
  assign cell_p3[0] = pd[0][LAT0-1][2];
  assign cell_p1[1] = pd[1][LAT1-1][0];
  assign cell_p2[1] = pd[1][LAT1-1][1];
  assign cell_p3[1] = pd[1][LAT1-1][2];
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask
  // monitor: every accepted result must match the head of the scoreboard
  always @(negedge clk)
    for (int g = 0; g < 2; g++)
      if (!reset && out_valid[g] && out_ready[g]) begin
        if (exp_q.size() == 0 || exp_q[0].id != g) begin
          n_total++;
          $display("FAIL unexpected_out%0d: got %h, required no result", g, out_result[g]);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("result%0d", g), out_result[g], e.val);
        end
      end
  task automatic issue(int g, logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] res, bit push);
    int t = 0;
    while (!in_ready[g] && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready_wait", {31'h0, in_ready[g]}, 32'd1);
    in_valid[g] = 1'b1;
    in_op[g] = op;
    in_src1[g] = a;
    in_src2[g] = b;
    if (push) exp_q.push_back('{g, res});
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
    in_src1[g] = $urandom;
    in_src2[g] = $urandom;
    in_op[g] = 2'($urandom);
  endtask
  task automatic run(int g, logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] res,
                     int lat, int pulses, string name);
    int n = 0;
    int p = 0;
    issue(g, op, a, b, res, 1'b1);
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (cell_en[g]) p++;
      if (out_valid[g]) break;
    end
    chk({name, "_lat"}, n, lat);
    chk({name, "_pulses"}, p, pulses);
    @(posedge clk); #1;
  endtask
  initial begin
    int t;
    logic [31:0] held;
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b0;
      out_ready[g] = 1'b1;
      in_op[g] = 2'd0;
      in_src1[g] = '0;
      in_src2[g] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready[0]}, 32'd1);
    chk("rst_out_valid", {31'h0, out_valid[0]}, 32'd0);
    chk("rst_cell_en", {31'h0, cell_en[0]}, 32'd0);
    chk("rst_out_result", out_result[0], 32'd0);
    chk("rst_cell_src1", cell_src1[0], 32'd0);
    chk("rst_cell_src2", cell_src2[0], 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run(0, 2'd0, 32'h0001_0002, 32'h0003_0004, 32'h000A_0008, 3, 1, "mul");
    run(0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 3, 1, "mul_ff");
    run(0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 2, "mulxuu");
    run(0, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 5, 2, "mulxss");
    run(0, 2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 5, 2, "mulxsu");
    run(0, 2'd2, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 5, 2, "mulxss_mixed");
    // consumer stalls in DONE while a new request waits
    out_ready[0] = 1'b0;
    issue(0, 2'd0, 32'd7, 32'd6, 32'd42, 1'b1);
    t = 0;
    while (!out_valid[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("hold_valid_seen", {31'h0, out_valid[0]}, 32'd1);
    held = 32'd42;
    in_valid[0] = 1'b1;
    in_op[0] = 2'd0;
    in_src1[0] = 32'd3;
    in_src2[0] = 32'd5;
    exp_q.push_back('{0, 32'd15});
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", {31'h0, out_valid[0]}, 32'd1);
      chk("hold_result", out_result[0], held);
      chk("hold_in_ready", {31'h0, in_ready[0]}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("reaccept_ready", {31'h0, in_ready[0]}, 32'd1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    t = 0;
    while (!out_valid[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("reaccept_done", {31'h0, out_valid[0]}, 32'd1);
    @(posedge clk); #1;
    // reset during the second cell pass discards the result
    issue(0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("wait2_rst_out_valid", {31'h0, out_valid[0]}, 32'd0);
    chk("wait2_rst_in_ready", {31'h0, in_ready[0]}, 32'd1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    run(0, 2'd0, 32'h0002_0003, 32'h0004_0005, 32'h0016_000F, 3, 1, "mul_after_reset");
    run(1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5, 1, "hi_off");
    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
